serial_sub16: RTL and testbench

- Bit-serial two's-complement subtractor. Computes diff = a − b over WIDTH bits, one bit per clock, LSB first, through a single full-subtractor cell.
- Sits beside the ripple-carry adder16 datapath as the area-minimal inverse operation: the subtract path for multi-cycle arithmetic where one gate-level cell is preferred to a WIDTH-wide array.
- Start/busy/done handshake.

---
 rtl/serial_sub16_pkg.sv | 20 ++
 rtl/serial_sub16_if.sv | 24 ++
 rtl/serial_sub16_fullsubtractor.sv | 15 +
 rtl/serial_sub16.sv | 118 +++++++++++
 tb/tb_serial_sub16.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub16_pkg.sv
// sub16_pkg: shared constants and types for the bit-serial subtractor.
//   SUB16_WIDTH : default operand/result width
//   state_e     : controller states (IDLE, RUN, DONE)
//   cnt_width() : bit counter width for a given operand width
package sub16_pkg;

    localparam int SUB16_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub16_if.sv
// serial_sub16_if: start/busy/done handshake plus operand/result bus.
//   master : drives start, a, b; observes busy, done, diff, borrow (ovf)
//   slave  : the subtractor side
//   ovf exists only when SERIAL_SUB16_OVF_EN is defined.
interface serial_sub16_if #(
    parameter int WIDTH = sub16_pkg::SUB16_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB16_OVF_EN
    logic             ovf;

    modport master (output start, a, b, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_sub16_fullsubtractor.sv
// fullsubtractor: one-bit subtract cell, the subtract twin of the fulladder.
//   x, y : minuend / subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fullsubtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub16.sv
// serial_sub16: bit-serial two's-complement subtractor, diff = a - b,
// LSB first, one bit per clock through a single fullsubtractor cell.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_sub16_if.slave (start/a/b in; busy/done/diff/borrow out)
// Optional signed-overflow output enabled by SERIAL_SUB16_OVF_EN.
module serial_sub16
    import sub16_pkg::*;
#(
    parameter int WIDTH = SUB16_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_sub16_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             d_bit, bout_bit;
`ifdef SERIAL_SUB16_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fullsubtractor u_cell (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (bor_q),
        .d   (d_bit),
        .bout(bout_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bor_d   = bor_q;
`ifdef SERIAL_SUB16_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    diff_d  = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB16_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {d_bit, diff_q[WIDTH-1:1]};
                bor_d  = bout_bit;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
`ifdef SERIAL_SUB16_OVF_EN
                    // On the last bit the operand MSBs have shifted down to bit 0.
                    ovf_d   = (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bor_q   <= 1'b0;
`ifdef SERIAL_SUB16_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bor_q   <= bor_d;
`ifdef SERIAL_SUB16_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == S_RUN);
    assign bus.done   = (state_q == S_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = bor_q;
`ifdef SERIAL_SUB16_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16: directed self-checking bench for serial_sub16 with a
// result scoreboard; expected results come from an arithmetic model.
module tb_serial_sub16;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t last;

    serial_sub16_if #(.WIDTH(W)) bus ();

    serial_sub16 #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.d  = av - bv;
        e.br = (av < bv);
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    // Called in cycle cyc0 after the start edge (cycle 1 = first cycle after it).
    // Done must appear in cycle W+1, with busy high in every cycle before it.
    task automatic wait_done(input string tag, input int cyc0);
        int  cyc;
        int  busy_cnt;
        int  overlap;
        bit  got;
        cyc      = cyc0;
        busy_cnt = 0;
        overlap  = 0;
        got      = 1'b0;
        while (cyc < 60 && !got) begin
            if (bus.busy && bus.done) overlap++;
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) busy_cnt++;
                tick();
                cyc++;
            end
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(cyc), 32'(W + 1));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1 - cyc0));
        chk({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e    = sb.pop_front();
            last = e;
            chk({tag, " diff"}, 32'(bus.diff), 32'(e.d));
            chk({tag, " borrow"}, 32'(bus.borrow), 32'(e.br));
`ifdef SERIAL_SUB16_OVF_EN
            chk({tag, " ovf"}, 32'(bus.ovf), 32'(e.ov));
`endif
        end
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        sb.push_back(model(av, bv));
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
    endtask

    // Full operation followed by one idle cycle: done must drop, result hold.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        launch(av, bv);
        wait_done(tag, 1);
        check_result(tag);
        tick();
        chk({tag, " done_pulse_single"}, 32'(bus.done), 32'd0);
        chk({tag, " diff_hold"}, 32'(bus.diff), 32'(last.d));
    endtask

    initial begin
        int done_seen;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset diff", 32'(bus.diff), 32'd0);
        chk("reset borrow", 32'(bus.borrow), 32'd0);
`ifdef SERIAL_SUB16_OVF_EN
        chk("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        do_op("5-3", 16'd5, 16'd3);
        do_op("3-5", 16'd3, 16'd5);
        do_op("8000-1", 16'h8000, 16'h0001);
        do_op("7fff-ffff", 16'h7FFF, 16'hFFFF);
        do_op("0-0", 16'h0000, 16'h0000);
        do_op("ffff-0", 16'hFFFF, 16'h0000);
        for (int i = 0; i < 4; i++) do_op("random", W'($urandom), W'($urandom));

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(16'd9, 16'd4);
        repeat (5) tick();
        bus.start = 1'b1;
        bus.a     = 16'd1;
        bus.b     = 16'd1;
        tick();
        bus.start = 1'b0;
        wait_done("ignored_start", 7);
        check_result("ignored_start");
        launch(16'd0, 16'd0);
        wait_done("b2b", 1);
        check_result("b2b");
        tick();

        // Reset mid-run aborts with no done pulse.
        launch(16'h1234, 16'h0101);
        void'(sb.pop_back());
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort diff", 32'(bus.diff), 32'd0);
        chk("abort borrow", 32'(bus.borrow), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.done) done_seen++;
            tick();
        end
        chk("abort no_done", 32'(done_seen), 32'd0);
        do_op("after_abort", 16'h00F0, 16'h000F);

        // Reset and start together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h0042;
        bus.b     = 16'h0001;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_vs_start busy", 32'(bus.busy), 32'd0);
        tick();
        chk("rst_vs_start idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
